// File: rtl/dtube_ctrl.sv
// AHB-lite seven-segment display controller: per-digit value/dp/blank/blink registers,
// static parallel segment outputs plus a time-multiplexed scan bus.
module dtube_ctrl #(
    parameter int          NUM_DIGITS = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          BLINK_DIV  = 25_000_000,
    parameter int          SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    HSELx,
    input  logic [31:0]             HADDR,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [1:0]              HTRANS,
    input  logic                    HMASTLOCK,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic [1:0]              HRESP,
    output logic [8*NUM_DIGITS-1:0] DTUBE_SEG,
    output logic [7:0]              SCAN_SEG,
    output logic [NUM_DIGITS-1:0]   SCAN_SEL
);

    localparam int         IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int         BW       = $clog2(BLINK_DIV);
    localparam int         SW       = $clog2(SCAN_DIV);
    localparam logic [3:0] SEL_CTRL = 4'd8;

    typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

    state_t r_state, w_state_next;

    logic [3:0]    r_val     [NUM_DIGITS];
    logic          r_dp      [NUM_DIGITS];
    logic          r_blank   [NUM_DIGITS];
    logic          r_blink   [NUM_DIGITS];
    logic          r_written [NUM_DIGITS];
    logic          r_en, r_mode;
    logic          r_wr_pend;
    logic [3:0]    r_wr_sel;
    logic [31:0]   r_hrdata;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_scan_idx;

    logic [31:0] w_offset, w_rd_val, w_fwd_val;
    logic [3:0]  w_sel;
    logic        w_is_ctrl, w_is_digit, w_active, w_fmt_ok, w_accept;
    logic        w_valid, w_err_req, w_fwd;
    logic [7:0]  w_digit_seg [NUM_DIGITS];
    logic        w_unused;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
        endcase
    endfunction

    assign w_unused = ^{HBURST, HMASTLOCK, HWDATA[31:7]};

    // Address-phase decode; BASE_ADDR is word aligned so offset[1:0] equals HADDR[1:0].
    assign w_offset   = HADDR - BASE_ADDR;
    assign w_is_ctrl  = (w_offset == 32'h20);
    assign w_is_digit = (w_offset[31:5] == 27'd0) && (w_offset[1:0] == 2'b00)
                        && ({1'b0, w_offset[4:2]} < 4'(NUM_DIGITS));
    assign w_sel      = w_is_ctrl ? SEL_CTRL : {1'b0, w_offset[4:2]};
    assign w_active   = HSELx && HTRANS[1];
    assign w_fmt_ok   = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);
    assign w_accept   = (r_state != ST_ERR1);
    assign w_valid    = w_accept && w_active && w_fmt_ok && (w_is_ctrl || w_is_digit);
    assign w_err_req  = w_accept && w_active && !(w_fmt_ok && (w_is_ctrl || w_is_digit));

    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel == SEL_CTRL) begin
            w_rd_val = {30'd0, r_mode, r_en};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_sel == 4'(i))
                    w_rd_val = {24'd0, r_written[i], r_blink[i], r_blank[i], r_dp[i], r_val[i]};
            end
        end
    end

    // A read landing on the data phase of a write to the same register sees the new value.
    assign w_fwd     = r_wr_pend && (r_wr_sel == w_sel);
    assign w_fwd_val = (w_sel == SEL_CTRL) ? {30'd0, HWDATA[1:0]} : {24'd0, 1'b1, HWDATA[6:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        HREADY       = 1'b1;
        HRESP        = 2'b00;
        case (r_state)
            ST_OK, ST_ERR2: begin
                w_state_next = w_err_req ? ST_ERR1 : ST_OK;
                HRESP        = (r_state == ST_ERR2) ? 2'b01 : 2'b00;
            end
            ST_ERR1: begin
                w_state_next = ST_ERR2;
                HREADY       = 1'b0;
                HRESP        = 2'b01;
            end
            default: w_state_next = ST_OK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b1;
            r_mode    <= 1'b0;
            r_wr_pend <= 1'b0;
            r_wr_sel  <= 4'd0;
            r_hrdata  <= 32'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_val[i]     <= 4'd0;
                r_dp[i]      <= 1'b0;
                r_blank[i]   <= 1'b0;
                r_blink[i]   <= 1'b0;
                r_written[i] <= 1'b0;
            end
        end else begin
            r_wr_pend <= w_valid && HWRITE;
            r_wr_sel  <= w_sel;
            r_hrdata  <= (w_valid && !HWRITE) ? (w_fwd ? w_fwd_val : w_rd_val) : 32'd0;
            if (r_wr_pend) begin
                if (r_wr_sel == SEL_CTRL) begin
                    r_en   <= HWDATA[0];
                    r_mode <= HWDATA[1];
                end
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (r_wr_sel == 4'(i)) begin
                        r_val[i]     <= HWDATA[3:0];
                        r_dp[i]      <= HWDATA[4];
                        r_blank[i]   <= HWDATA[5];
                        r_blink[i]   <= HWDATA[6];
                        r_written[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign HRDATA = r_hrdata;

    always_ff @(posedge clk) begin
        if (rst || !r_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= !r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Holding at 0 while mode=0 makes every 0->1 mode change restart the scan from digit 0.
    always_ff @(posedge clk) begin
        if (rst || !r_mode) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_comb begin
        DTUBE_SEG = '1;
        SCAN_SEL  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit_seg[i] = 8'hFF;
            if (r_en && r_written[i] && !r_blank[i] && !(r_blink[i] && r_blink_phase)) begin
                w_digit_seg[i] = glyph(r_val[i]);
                if (r_dp[i])
                    w_digit_seg[i][7] = 1'b0;
            end
            DTUBE_SEG[8*i +: 8] = w_digit_seg[i];
            if (r_mode && (r_scan_idx == IW'(i)))
                SCAN_SEL[i] = 1'b0;
        end
    end

    assign SCAN_SEG = r_mode ? w_digit_seg[r_scan_idx] : 8'hFF;

endmodule

// File: doc/dtube_ctrl.md
# dtube_ctrl

Parametrised AHB-lite seven-segment display controller that drives NUM_DIGITS digits. It adds per-digit decimal point, blanking and blink control, and a global enable. Digits can be driven in parallel (static) or time-multiplexed (scan) for boards with shared segment lines. It sits on the peripheral AHB-lite bus as a slave, alongside the other memory-mapped I/O.

## Interface
- NUM_DIGITS, 6, number of digits; legal range 1..8
- BASE_ADDR, 32'h0000_0000, word-aligned base address of the register window
- BLINK_DIV, 25_000_000, clk cycles per blink half-period; minimum 2
- SCAN_DIV, 1000, clk cycles each digit is held in scan mode; minimum 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- HSELx, HADDR[`WORD_WIDTH], HWRITE, HSIZE[3], HBURST[3], HTRANS[2], HMASTLOCK, HWDATA[`WORD_WIDTH]  in  AHB-lite slave inputs; HBURST and HMASTLOCK are ignored
- HRDATA  out  `WORD_WIDTH  read data
- HREADY  out  1  transfer done
- HRESP  out  2  OKAY/ERROR
- DTUBE_SEG  out  8*NUM_DIGITS  static segments; digit i occupies [8i+7:8i]
- SCAN_SEG  out  8  multiplexed segment bus
- SCAN_SEL  out  NUM_DIGITS  one-hot, active-low digit select

## Operation
- Segment code is active-low. Bit 7 is the dp (0 = lit); bits 6:0 are g..a.
- Digit glyphs: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E (hex).
- Register map (offset from BASE_ADDR):
  - DIGIT[i] at 4*i, i < NUM_DIGITS:
    - [3:0] val (RW)
    - [4] dp (RW)
    - [5] blank (RW)
    - [6] blink (RW)
    - [7] written (RO; set by first write, cleared by reset)
    - other bits read 0
  - CTRL at 0x20:
    - [0] en (RW, reset 1)
    - [1] mode (RW, reset 0; 0 = static, 1 = scan)
- Digit output rule, evaluated in order:
  - 8'hFF if !en, !written, blank, or (blink && blink_phase)
  - otherwise glyph(val), with bit 7 cleared when dp=1
- Blink counter:
  - counts 0..BLINK_DIV-1, wraps, and toggles blink_phase on each wrap
  - free-running while en=1; held at 0 with blink_phase=0 while en=0
- Scan counter:
  - counts 0..SCAN_DIV-1 while mode=1
  - on wrap, scan_idx advances by 1 and wraps from NUM_DIGITS-1 to 0
  - when mode=0, counter and scan_idx are held at 0
- Scan outputs:
  - mode=1: SCAN_SEG = digit[scan_idx]; SCAN_SEL has bit scan_idx = 0, all others 1
  - mode=0: SCAN_SEG = FF and SCAN_SEL = all 1s
- DTUBE_SEG is always valid, independent of mode.
- Valid transfer: HSELx && HTRANS==NONSEQ or SEQ, HSIZE==word, HADDR[1:0]==0, and offset maps to a register.
- Error cases: selected NONSEQ/SEQ with an unmapped offset, a digit index ≥ NUM_DIGITS, or bad size/alignment.
  - Response is a two-cycle AHB ERROR: cycle 1 HREADY=0/HRESP=ERROR, cycle 2 HREADY=1/HRESP=ERROR.
  - No register changes.
- IDLE, BUSY, or !HSELx: OKAY, zero wait, no effect.

## Timing
- Reset values:
  - HRDATA=0, HREADY=1, HRESP=OKAY
  - all digit fields and written = 0; en=1, mode=0
  - counters 0, blink_phase=0, scan_idx=0
  - DTUBE_SEG all FF, SCAN_SEG=FF, SCAN_SEL all 1s
- Address phase is sampled at edge N. The write is applied from HWDATA at edge N+1 (data phase); the new value is visible on outputs after edge N+1.
- Reads: HRDATA is registered at edge N and valid during the data phase. Non-read data phases drive HRDATA=0.
- Read-after-write forwarding: if a read address phase coincides with the data phase of a write to the same register, HRDATA returns the newly written value (masked to defined bits, written=1).
- Valid transfers are zero-wait: HREADY=1, HRESP=OKAY.
- During an error response's first cycle, the slave ignores any address phase presented (the master must cancel it per AHB).
- Reset asserted mid-transfer or mid-error: all state returns to reset values at the next edge, and any pending write is discarded.
- Writes to CTRL.mode take effect from the next edge. The scan counter and scan_idx restart from 0 on a 0→1 mode change.

## Test plan
- Reset, then read DIGIT0 and CTRL → 0x00 and 0x01; DTUBE_SEG all FF; SCAN_SEL all 1s.
- Write DIGIT2=0x1A (val A, dp) → DTUBE_SEG[23:16]=0x08; DIGIT2 reads 0x9A; other digits remain FF.
- Back-to-back write DIGIT0=0x3, then read DIGIT0 in the next address phase → HRDATA=0x83 (forwarded).
- Access offset 0x1C with NUM_DIGITS=6, or HADDR[1:0]=2 → cycle 1 HREADY=0/ERROR, cycle 2 HREADY=1/ERROR; no register changes.
- BLINK_DIV=4, DIGIT1=0x45 (blink, 5) → DIGIT1 output alternates 0x92 and FF every 4 cycles. Clearing en freezes the output at FF.
- SCAN_DIV=3, NUM_DIGITS=3, mode=1, digits 1/2/3 → SCAN_SEL steps 110→101→011→110 every 3 cycles, with SCAN_SEG F9/A4/B0 in step.
